// File: rtl/instr_stream_writer.sv
// Packs decoded instruction fields into 3-word images and writes them, then a 16'hFFFF halt word.
// Optional WRITER_AUTOHALT_EN: a legal instruction that does not fit closes the image directly.
module instr_stream_writer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cmp_neg,
  input  logic [1:0]        cmp_op,
  input  logic              dst_op,
  input  logic [5:0]        cmp_reg,
  input  logic [5:0]        dst_reg,
  input  logic [15:0]       cmp_imm,
  input  logic [15:0]       dst_imm,
  input  logic              finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  typedef enum logic [2:0] {StIdle, StWOp, StWCmp, StWDst, StWHlt, StDone} state_e;

  localparam logic [ADDR_W:0] LpDepth = (ADDR_W+1)'(DEPTH);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_wptr;
  logic [15:0]       r_opcode, r_cmp_imm, r_dst_imm;
  logic              r_err_illegal, r_err_full;
  logic              w_accept, w_illegal, w_full;

  assign w_accept  = (r_state == StIdle) && in_valid;
  assign w_illegal = (cmp_op == 2'd3);
  // One word stays reserved so the halt word always fits.
  assign w_full    = ({1'b0, r_wptr} + (ADDR_W+1)'(4)) > LpDepth;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (w_illegal) begin
            w_state_d = StIdle;
          end else if (w_full) begin
`ifdef WRITER_AUTOHALT_EN
            w_state_d = StWHlt;
`else
            w_state_d = StIdle;
`endif
          end else begin
            w_state_d = StWOp;
          end
        end else if (finish) begin
          w_state_d = StWHlt;
        end
      end
      StWOp:   w_state_d = StWCmp;
      StWCmp:  w_state_d = StWDst;
      StWDst:  w_state_d = StIdle;
      StWHlt:  w_state_d = StDone;
      StDone:  w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      StWOp:  begin mem_we = 1'b1; mem_addr = r_wptr; mem_wdata = r_opcode;  end
      StWCmp: begin mem_we = 1'b1; mem_addr = r_wptr; mem_wdata = r_cmp_imm; end
      StWDst: begin mem_we = 1'b1; mem_addr = r_wptr; mem_wdata = r_dst_imm; end
      StWHlt: begin mem_we = 1'b1; mem_addr = r_wptr; mem_wdata = 16'hFFFF;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_wptr        <= '0;
      r_opcode      <= '0;
      r_cmp_imm     <= '0;
      r_dst_imm     <= '0;
      r_err_illegal <= 1'b0;
      r_err_full    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_opcode  <= {cmp_neg, cmp_op, dst_op, cmp_reg, dst_reg};
        r_cmp_imm <= cmp_imm;
        r_dst_imm <= dst_imm;
      end
      if (w_accept && w_illegal) r_err_illegal <= 1'b1;
      if (w_accept && !w_illegal && w_full) r_err_full <= 1'b1;
      if (mem_we) r_wptr <= r_wptr + 1'b1;
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign done        = (r_state == StDone);
  assign word_count  = r_wptr;
  assign err_illegal = r_err_illegal;
  assign err_full    = r_err_full;

endmodule

// File: tb/tb_instr_stream_writer.sv
// Scoreboard bench: stimulus pushes expected memory writes, a monitor pops them on every mem_we.
module tb_instr_stream_writer;
  localparam int unsigned AW = 16;
  localparam int unsigned DP = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          cmp_neg = 1'b0;
  logic [1:0]    cmp_op = '0;
  logic          dst_op = 1'b0;
  logic [5:0]    cmp_reg = '0;
  logic [5:0]    dst_reg = '0;
  logic [15:0]   cmp_imm = '0;
  logic [15:0]   dst_imm = '0;
  logic          finish = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW-1:0] word_count;
  logic          done;
  logic          err_illegal;
  logic          err_full;

  instr_stream_writer #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_neg(cmp_neg), .cmp_op(cmp_op), .dst_op(dst_op), .cmp_reg(cmp_reg),
    .dst_reg(dst_reg), .cmp_imm(cmp_imm), .dst_imm(dst_imm), .finish(finish),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .done(done), .err_illegal(err_illegal), .err_full(err_full)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          m_wptr;
  bit          m_ill, m_full, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_wdata, e[31:16], e[15:0]);
        end
      end
    end
  end

  function automatic void push_word(input int addr, input logic [15:0] data);
    exp_q.push_back({addr[15:0], data});
  endfunction

  // Returns 1 if the model expects the three words to be written.
  function automatic bit model_instr(input bit neg, input int op, input bit dop, input int creg,
                                     input int dreg, input logic [15:0] ci, input logic [15:0] di);
    int opc;
    if (op == 3) begin
      m_ill = 1;
      return 0;
    end
    if (m_wptr + 4 > int'(DP)) begin
      m_full = 1;
`ifdef WRITER_AUTOHALT_EN
      push_word(m_wptr, 16'hFFFF);
      m_wptr++;
      m_done = 1;
`endif
      return 0;
    end
    opc = neg * 32768 + op * 8192 + dop * 4096 + creg * 64 + dreg;
    push_word(m_wptr, opc[15:0]);
    push_word(m_wptr + 1, ci);
    push_word(m_wptr + 2, di);
    m_wptr += 3;
    return 1;
  endfunction

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drive(input bit neg, input int op, input bit dop, input int creg,
                       input int dreg, input logic [15:0] ci, input logic [15:0] di,
                       input bit fin);
    cmp_neg  = neg;
    cmp_op   = op[1:0];
    dst_op   = dop;
    cmp_reg  = creg[5:0];
    dst_reg  = dreg[5:0];
    cmp_imm  = ci;
    dst_imm  = di;
    in_valid = 1'b1;
    finish   = fin;
  endtask

  task automatic send(input bit neg, input int op, input bit dop, input int creg,
                      input int dreg, input logic [15:0] ci, input logic [15:0] di,
                      input bit fin);
    bit ok, wr;
    int low, exp_low;
    wait_ready(ok);
    if (!ok) return;
    drive(neg, op, dop, creg, dreg, ci, di, fin);
    wr = model_instr(neg, op, dop, creg, dreg, ci, di);
    exp_low = wr ? 3 : (m_done ? 1 : 0);
    @(negedge clk);
    in_valid = 1'b0;
    low = 0;
    while (!in_ready && !done && low < 10) begin
      low++;
      @(negedge clk);
    end
    check("ready_low_cycles", low, exp_low);
    check("word_count", 32'(word_count), m_wptr);
    check("err_illegal", 32'(err_illegal), 32'(m_ill));
    check("err_full", 32'(err_full), 32'(m_full));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic do_finish();
    int t = 0;
    int wc;
    finish = 1'b1;
    if (!m_done) begin
      push_word(m_wptr, 16'hFFFF);
      m_wptr++;
      m_done = 1;
    end
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    finish = 1'b0;
    check("done_after_finish", 32'(done), 32'd1);
    check("final_word_count", 32'(word_count), m_wptr);
    check("ready_in_done", 32'(in_ready), 32'd0);
    // DONE must ignore further instructions and finish requests.
    wc = int'(word_count);
    drive(1'b0, 0, 1'b0, 1, 2, 16'h1234, 16'h5678, 1'b1);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    finish   = 1'b0;
    check("count_frozen_in_done", 32'(word_count), wc);
  endtask

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    reset = 1'b1;
    in_valid = 1'b0;
    finish = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_wptr = 0;
    m_ill = 0;
    m_full = 0;
    m_done = 0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_mem", {15'd0, mem_we, mem_wdata}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_flags", {29'd0, done, err_illegal, err_full}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    @(negedge clk);
    do_reset();

    send(1'b0, 2, 1'b1, 5, 3, 16'hFFFC, 16'h000A, 1'b0);
    send(1'b1, 3, 1'b0, 7, 9, 16'h0001, 16'h0002, 1'b0);
    do_finish();

    do_reset();
    send(1'b1, 0, 1'b0, 63, 0, 16'h8000, 16'h7FFF, 1'b0);
    send(1'b0, 1, 1'b1, 0, 63, 16'h0100, 16'hFF00, 1'b0);
    send(1'b0, 2, 1'b0, 10, 20, 16'h0003, 16'h0004, 1'b0);
    do_finish();

    do_reset();
    send(1'b0, 1, 1'b0, 2, 4, 16'hAAAA, 16'h5555, 1'b1);
    do_finish();

    // Reset during W_CMP: only the opcode and cmp words reach memory.
    do_reset();
    send(1'b0, 3, 1'b0, 1, 1, 16'h0, 16'h0, 1'b0);
    wait_ready(ok);
    drive(1'b1, 1, 1'b1, 33, 44, 16'hBEEF, 16'hCAFE, 1'b0);
    push_word(0, 16'(32768 + 8192 + 4096 + 33 * 64 + 44));
    push_word(1, 16'hBEEF);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_we", 32'(mem_we), 32'd0);
    check("midreset_count", 32'(word_count), 32'd0);
    check("midreset_ready", 32'(in_ready), 32'd1);
    check("midreset_flags", {30'd0, err_illegal, err_full}, 32'd0);
    m_wptr = 0;
    m_ill = 0;

    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        bit fin;
        if (m_done) break;
        fin = ($urandom_range(0, 7) == 0);
        send(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             16'($urandom), 16'($urandom), fin);
        if (fin) break;
      end
      do_finish();
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
